// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing defaults, pipeline control word and colour-bar lookup.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int BAR_COUNT = 8;

    typedef enum logic [2:0] {
        BAR_WHITE   = 3'd0,
        BAR_YELLOW  = 3'd1,
        BAR_CYAN    = 3'd2,
        BAR_GREEN   = 3'd3,
        BAR_MAGENTA = 3'd4,
        BAR_RED     = 3'd5,
        BAR_BLUE    = 3'd6,
        BAR_BLACK   = 3'd7
    } bar_e;

    // Control bits that travel alongside the pixel read.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
        logic ls;
    } vga_ctrl_t;

    localparam int CTRL_W = $bits(vga_ctrl_t);

    // Returns per-channel on/off flags ordered {B,G,R}.
    function automatic logic [2:0] bar_bgr(input bar_e idx);
        logic [2:0] bgr;
        case (idx)
            BAR_WHITE:   bgr = 3'b111;
            BAR_YELLOW:  bgr = 3'b011;
            BAR_CYAN:    bgr = 3'b110;
            BAR_GREEN:   bgr = 3'b010;
            BAR_MAGENTA: bgr = 3'b101;
            BAR_RED:     bgr = 3'b001;
            BAR_BLUE:    bgr = 3'b100;
            default:     bgr = 3'b000;
        endcase
        return bgr;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Parametrised shift register carrying control bits across the RAM read latency.
// DEPTH = 0 collapses to a wire.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_25mHz,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q_o = d_i;
        end else begin : g_shift
            logic [DEPTH*WIDTH-1:0] sr_q;
            logic [DEPTH*WIDTH-1:0] sr_d;

            if (DEPTH == 1) begin : g_one
                assign sr_d = d_i;
            end else begin : g_many
                assign sr_d = {sr_q[(DEPTH-1)*WIDTH-1:0], d_i};
            end

            always_ff @(posedge clk_25mHz or posedge rst) begin
                if (rst) begin
                    sr_q <= '0;
                end else begin
                    sr_q <= sr_d;
                end
            end

            assign q_o = sr_q[DEPTH*WIDTH-1 -: WIDTH];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator with pixel-RAM addressing and read-latency alignment.
// Define VGA_TESTPAT_EN to build the colour-bar test pattern selected by tp_en.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = 4,
    parameter int RD_LAT   = 1,
    localparam int ROW_W   = $clog2(V_ACTIVE),
    localparam int COL_W   = $clog2(H_ACTIVE)
) (
    input  logic                 clk_25mHz,
    input  logic                 rst,
    input  logic [3*COLOR_W-1:0] Din,
    input  logic                 tp_en,
    output logic [ROW_W-1:0]     row,
    output logic [COL_W-1:0]     col,
    output logic                 rdn,
    output logic [COLOR_W-1:0]   R,
    output logic [COLOR_W-1:0]   G,
    output logic [COLOR_W-1:0]   B,
    output logic                 HS,
    output logic                 VS,
    output logic                 DE,
    output logic                 frame_start,
    output logic                 line_start
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_CNT_W = $clog2(H_TOTAL);
    localparam int V_CNT_W = $clog2(V_TOTAL);

    localparam logic [H_CNT_W-1:0] H_SYNC_C  = H_CNT_W'(H_SYNC);
    localparam logic [H_CNT_W-1:0] H_START_C = H_CNT_W'(H_SYNC + H_BP);
    localparam logic [H_CNT_W-1:0] H_END_C   = H_CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [H_CNT_W-1:0] H_LAST_C  = H_CNT_W'(H_TOTAL - 1);
    localparam logic [H_CNT_W-1:0] H_ONE_C   = H_CNT_W'(1);
    localparam logic [V_CNT_W-1:0] V_SYNC_C  = V_CNT_W'(V_SYNC);
    localparam logic [V_CNT_W-1:0] V_START_C = V_CNT_W'(V_SYNC + V_BP);
    localparam logic [V_CNT_W-1:0] V_END_C   = V_CNT_W'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [V_CNT_W-1:0] V_LAST_C  = V_CNT_W'(V_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] V_ONE_C   = V_CNT_W'(1);

`ifdef VGA_TESTPAT_EN
    localparam int BAR_BITS = 3;
`else
    localparam int BAR_BITS = 0;
`endif
    localparam int PIPE_W = CTRL_W + BAR_BITS;

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q + H_ONE_C;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST_C) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + V_ONE_C;
        end
    end

    always_ff @(posedge clk_25mHz or posedge rst) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Count-time decode
    logic      hs_raw, vs_raw, h_act, v_act, act;
    vga_ctrl_t ctrl_d;

    always_comb begin
        hs_raw    = (h_cnt_q < H_SYNC_C);
        vs_raw    = (v_cnt_q < V_SYNC_C);
        h_act     = (h_cnt_q >= H_START_C) && (h_cnt_q < H_END_C);
        v_act     = (v_cnt_q >= V_START_C) && (v_cnt_q < V_END_C);
        act       = h_act && v_act;
        ctrl_d.hs = hs_raw;
        ctrl_d.vs = vs_raw;
        ctrl_d.de = act;
        ctrl_d.ls = (h_cnt_q == H_START_C) && v_act;
        ctrl_d.fs = (h_cnt_q == H_START_C) && (v_cnt_q == V_START_C);
    end

    // ------------------------------------------------------------------
    // Stage A: RAM address, read strobe and control snapshot
    // ------------------------------------------------------------------
    logic [H_CNT_W-1:0] h_diff;
    logic [V_CNT_W-1:0] v_diff;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               rdn_q, rdn_d;
    vga_ctrl_t          ctrl_a_q;

    always_comb begin
        h_diff = h_cnt_q - H_START_C;
        v_diff = v_cnt_q - V_START_C;
        col_d  = h_diff[COL_W-1:0];
        row_d  = v_diff[ROW_W-1:0];
        rdn_d  = ~act;
    end

    always_ff @(posedge clk_25mHz or posedge rst) begin
        if (rst) begin
            row_q    <= '0;
            col_q    <= '0;
            rdn_q    <= 1'b1;
            ctrl_a_q <= '0;
        end else begin
            row_q    <= row_d;
            col_q    <= col_d;
            rdn_q    <= rdn_d;
            ctrl_a_q <= ctrl_d;
        end
    end

    assign row = row_q;
    assign col = col_q;
    assign rdn = rdn_q;

    logic [PIPE_W-1:0] pipe_in, pipe_out;

`ifdef VGA_TESTPAT_EN
    localparam int BAR_W    = H_ACTIVE / BAR_COUNT;
    localparam int BAR_PX_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BAR_PX_W-1:0] BAR_LAST_C = BAR_PX_W'(BAR_W - 1);
    localparam logic [BAR_PX_W-1:0] BAR_ONE_C  = BAR_PX_W'(1);

    // Bar counter is registered with col so its value always names col_q's bar.
    logic [BAR_PX_W-1:0] bar_px_q, bar_px_d;
    logic [2:0]          bar_idx_q, bar_idx_d;

    always_comb begin
        bar_px_d  = bar_px_q;
        bar_idx_d = bar_idx_q;
        if (h_cnt_q == H_START_C) begin
            bar_px_d  = '0;
            bar_idx_d = '0;
        end else if (h_act) begin
            if (bar_px_q == BAR_LAST_C) begin
                bar_px_d  = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_px_d  = bar_px_q + BAR_ONE_C;
            end
        end
    end

    always_ff @(posedge clk_25mHz or posedge rst) begin
        if (rst) begin
            bar_px_q  <= '0;
            bar_idx_q <= '0;
        end else begin
            bar_px_q  <= bar_px_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    assign pipe_in = {bar_idx_q, ctrl_a_q};
`else
    assign pipe_in = ctrl_a_q;
`endif

    vga_delay_line #(
        .WIDTH (PIPE_W),
        .DEPTH (RD_LAT)
    ) u_delay (
        .clk_25mHz (clk_25mHz),
        .rst       (rst),
        .d_i       (pipe_in),
        .q_o       (pipe_out)
    );

    // ------------------------------------------------------------------
    // Stage B: pin registers
    // ------------------------------------------------------------------
    vga_ctrl_t            ctrl_b;
    logic [3*COLOR_W-1:0] pix_src;
    logic [3*COLOR_W-1:0] rgb_q, rgb_d;
    logic                 hs_q, vs_q, de_q, fs_q, ls_q;

    assign ctrl_b = vga_ctrl_t'(pipe_out[CTRL_W-1:0]);

`ifdef VGA_TESTPAT_EN
    logic [2:0] bar_bgr_b;
    assign bar_bgr_b = bar_bgr(bar_e'(pipe_out[PIPE_W-1 -: 3]));

    always_comb begin
        pix_src = Din;
        if (tp_en) begin
            pix_src = {{COLOR_W{bar_bgr_b[2]}}, {COLOR_W{bar_bgr_b[1]}}, {COLOR_W{bar_bgr_b[0]}}};
        end
    end
`else
    logic unused_tp_en;
    assign unused_tp_en = tp_en;
    assign pix_src      = Din;
`endif

    // Blanking is forced here so nothing leaks out while DE is low.
    assign rgb_d = ctrl_b.de ? pix_src : '0;

    always_ff @(posedge clk_25mHz or posedge rst) begin
        if (rst) begin
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            de_q  <= 1'b0;
            fs_q  <= 1'b0;
            ls_q  <= 1'b0;
            rgb_q <= '0;
        end else begin
            hs_q  <= ctrl_b.hs ~^ HS_POL;
            vs_q  <= ctrl_b.vs ~^ VS_POL;
            de_q  <= ctrl_b.de;
            fs_q  <= ctrl_b.fs;
            ls_q  <= ctrl_b.ls;
            rgb_q <= rgb_d;
        end
    end

    assign HS          = hs_q;
    assign VS          = vs_q;
    assign DE          = de_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign R           = rgb_q[COLOR_W-1:0];
    assign G           = rgb_q[2*COLOR_W-1:COLOR_W];
    assign B           = rgb_q[3*COLOR_W-1:2*COLOR_W];

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl on a shrunk 16x8 raster, two latency/polarity builds.
module tb_vga_timing_ctrl;

    localparam int HA = 16, HF = 2, HSY = 4, HB = 3;
    localparam int VA = 8,  VF = 1, VSY = 2, VB = 2;
    localparam int HT = HSY + HB + HA + HF;   // 25
    localparam int VT = VSY + VB + VA + VF;   // 13
    localparam int FRAME = HT * VT;           // 325
    localparam int LAT0 = 1, LAT1 = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tp_en = 1'b0;
    logic [11:0] din0 = '0, din1 = '0;

    logic [2:0]  row0, row1;
    logic [3:0]  col0, col1;
    logic        rdn0, rdn1;
    logic [3:0]  r0, g0, b0, r1, g1, b1;
    logic        hs0, vs0, de0, fs0, ls0;
    logic        hs1, vs1, de1, fs1, ls1;

    always #20 clk = ~clk;

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4), .RD_LAT(LAT0)
    ) dut0 (
        .clk_25mHz(clk), .rst(rst), .Din(din0), .tp_en(tp_en),
        .row(row0), .col(col0), .rdn(rdn0), .R(r0), .G(g0), .B(b0),
        .HS(hs0), .VS(vs0), .DE(de0), .frame_start(fs0), .line_start(ls0)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(4), .RD_LAT(LAT1)
    ) dut1 (
        .clk_25mHz(clk), .rst(rst), .Din(din1), .tp_en(tp_en),
        .row(row1), .col(col1), .rdn(rdn1), .R(r1), .G(g1), .B(b1),
        .HS(hs1), .VS(vs1), .DE(de1), .frame_start(fs1), .line_start(ls1)
    );

    typedef struct packed {
        logic       hs_act;
        logic       vs_act;
        logic       de;
        logic       fs;
        logic       ls;
        logic [2:0] row;
        logic [3:0] col;
    } exp_t;

    // {B,G,R}: white, yellow, cyan, green, magenta, red, blue, black
    logic [11:0] bar_tab [8] = '{12'hFFF, 12'h0FF, 12'hFF0, 12'h0F0,
                                 12'hF0F, 12'h00F, 12'hF00, 12'h000};

    int n_checks = 0;
    int n_fail   = 0;

    int first_rdn0, first_de0, first_de1, first_fs0, first_fs1;
    logic [6:0] first_addr0;
    int cnt_hs0, cnt_vs0, cnt_de0, cnt_ls0, cnt_fs0;
    int cnt_hs1, cnt_de1, cnt_fs1;
    int err_a, err_sync0, err_rgb0, err_sync1, err_rgb1, err_blank;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pix(input logic [2:0] rw, input logic [3:0] cl);
        return {1'b1, rw, cl, 4'hC};
    endfunction

    // Expected raster state for count index c (c < 0: pipeline still cleared).
    function automatic exp_t model(input int c);
        exp_t e;
        int h, v;
        e = '0;
        if (c >= 0) begin
            h = c % HT;
            v = (c / HT) % VT;
            e.hs_act = (h < HSY);
            e.vs_act = (v < VSY);
            e.de     = (h >= HSY + HB) && (h < HSY + HB + HA) && (v >= VSY + VB) && (v < VSY + VB + VA);
            e.fs     = (h == HSY + HB) && (v == VSY + VB);
            e.ls     = (h == HSY + HB) && (v >= VSY + VB) && (v < VSY + VB + VA);
            e.row    = 3'(v - (VSY + VB));
            e.col    = 4'(h - (HSY + HB));
        end
        return e;
    endfunction

    function automatic logic [11:0] exp_rgb(input exp_t e, input logic tp);
        logic [11:0] v;
        v = '0;
        if (e.de) begin
            v = pix(e.row, e.col);
`ifdef VGA_TESTPAT_EN
            if (tp) v = bar_tab[e.col / 2];
`endif
        end
        return v;
    endfunction

    // Runs n cycles from reset release; entered at the negedge just after release.
    task automatic run(input int n, input int tp_lo, input int tp_hi);
        logic [6:0] ah0 [4];
        logic [6:0] ah1 [4];
        exp_t a, e0, e1;
        logic tp_now;
        for (int i = 0; i < 4; i++) begin
            ah0[i] = '0;
            ah1[i] = '0;
        end
        first_rdn0 = -1; first_de0 = -1; first_de1 = -1; first_fs0 = -1; first_fs1 = -1;
        first_addr0 = '0;
        cnt_hs0 = 0; cnt_vs0 = 0; cnt_de0 = 0; cnt_ls0 = 0; cnt_fs0 = 0;
        cnt_hs1 = 0; cnt_de1 = 0; cnt_fs1 = 0;
        err_a = 0; err_sync0 = 0; err_rgb0 = 0; err_sync1 = 0; err_rgb1 = 0; err_blank = 0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            tp_now = tp_en;
            a  = model(k - 1);
            e0 = model(k - LAT0 - 2);
            e1 = model(k - LAT1 - 2);

            if (rdn0 !== ~a.de || rdn1 !== ~a.de) err_a++;
            if (a.de && ({row0, col0} !== {a.row, a.col} || {row1, col1} !== {a.row, a.col})) err_a++;

            if (hs0 !== ~e0.hs_act || vs0 !== ~e0.vs_act || de0 !== e0.de ||
                fs0 !== e0.fs || ls0 !== e0.ls) err_sync0++;
            if (hs1 !== e1.hs_act || vs1 !== e1.vs_act || de1 !== e1.de ||
                fs1 !== e1.fs || ls1 !== e1.ls) err_sync1++;
            if ({b0, g0, r0} !== exp_rgb(e0, tp_now)) err_rgb0++;
            if ({b1, g1, r1} !== exp_rgb(e1, tp_now)) err_rgb1++;
            if ((!de0 && {b0, g0, r0} != 12'h0) || (!de1 && {b1, g1, r1} != 12'h0)) err_blank++;

            if (k >= LAT0 + 2 && k < LAT0 + 2 + 2 * FRAME) begin
                if (!hs0) cnt_hs0++;
                if (!vs0) cnt_vs0++;
                if (de0)  cnt_de0++;
                if (ls0)  cnt_ls0++;
                if (fs0)  cnt_fs0++;
            end
            if (k >= LAT1 + 2 && k < LAT1 + 2 + 2 * FRAME) begin
                if (hs1) cnt_hs1++;
                if (de1) cnt_de1++;
                if (fs1) cnt_fs1++;
            end

            if (first_rdn0 < 0 && !rdn0) begin
                first_rdn0  = k;
                first_addr0 = {row0, col0};
            end
            if (first_de0 < 0 && de0) first_de0 = k;
            if (first_de1 < 0 && de1) first_de1 = k;
            if (first_fs0 < 0 && fs0) first_fs0 = k;
            if (first_fs1 < 0 && fs1) first_fs1 = k;

            // Frame-buffer RAM model: Din follows the address RD_LAT cycles later.
            for (int i = 3; i > 0; i--) begin
                ah0[i] = ah0[i-1];
                ah1[i] = ah1[i-1];
            end
            ah0[0] = {row0, col0};
            ah1[0] = {row1, col1};
            din0 = pix(ah0[LAT0][6:4], ah0[LAT0][3:0]);
            din1 = pix(ah1[LAT1][6:4], ah1[LAT1][3:0]);
            tp_en = (k >= tp_lo) && (k < tp_hi);
        end
    endtask

    task automatic check_reset_pins(input string tag);
        check_val({tag, "_rdn"},   {rdn1, rdn0}, 2'b11);
        check_val({tag, "_addr"},  {row1, col1, row0, col0}, 14'h0);
        check_val({tag, "_de"},    {de1, de0}, 2'b00);
        check_val({tag, "_rgb0"},  {b0, g0, r0}, 12'h000);
        check_val({tag, "_rgb1"},  {b1, g1, r1}, 12'h000);
        check_val({tag, "_sync0"}, {hs0, vs0}, 2'b11);
        check_val({tag, "_sync1"}, {hs1, vs1}, 2'b00);
        check_val({tag, "_strb"},  {fs1, ls1, fs0, ls0}, 4'h0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_pins("por");
        $display("reset state checked");
        rst = 1'b0;

        run(2 * FRAME + 170, -1, -1);
        check_val("first_rdn0_cycle", first_rdn0, 32'd108);
        check_val("first_rdn0_addr",  first_addr0, 7'h00);
        check_val("first_de0_cycle",  first_de0, 32'd110);
        check_val("first_de1_cycle",  first_de1, 32'd112);
        check_val("first_fs0_cycle",  first_fs0, 32'd110);
        check_val("first_fs1_cycle",  first_fs1, 32'd112);
        check_val("hs0_low_cycles",   cnt_hs0, 32'd104);
        check_val("vs0_low_cycles",   cnt_vs0, 32'd100);
        check_val("de0_cycles",       cnt_de0, 32'd256);
        check_val("ls0_pulses",       cnt_ls0, 32'd16);
        check_val("fs0_pulses",       cnt_fs0, 32'd2);
        check_val("hs1_high_cycles",  cnt_hs1, 32'd104);
        check_val("de1_cycles",       cnt_de1, 32'd256);
        check_val("fs1_pulses",       cnt_fs1, 32'd2);
        check_val("stagea_errs",      err_a, 32'd0);
        check_val("sync0_errs",       err_sync0, 32'd0);
        check_val("sync1_errs",       err_sync1, 32'd0);
        check_val("rgb0_errs",        err_rgb0, 32'd0);
        check_val("rgb1_errs",        err_rgb1, 32'd0);
        check_val("blank_errs",       err_blank, 32'd0);
        $display("two-frame run: rdn@%0d de0@%0d de1@%0d de0_cnt=%0d", first_rdn0, first_de0, first_de1, cnt_de0);

        // Mid-frame reset while pixels are active: outputs must clear at once.
        check_val("midframe_de_before", {de1, de0}, 2'b11);
        rst = 1'b1;
        #1;
        check_reset_pins("async");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        $display("mid-frame reset applied for 3 cycles");

        run(500, 440, 480);
        check_val("rst_fs0_cycle", first_fs0, 32'd110);
        check_val("rst_fs1_cycle", first_fs1, 32'd112);
        check_val("tp_stagea_errs", err_a, 32'd0);
        check_val("tp_sync0_errs",  err_sync0, 32'd0);
        check_val("tp_sync1_errs",  err_sync1, 32'd0);
        check_val("tp_rgb0_errs",   err_rgb0, 32'd0);
        check_val("tp_rgb1_errs",   err_rgb1, 32'd0);
        check_val("tp_blank_errs",  err_blank, 32'd0);
        $display("post-reset run with tp_en window: fs0@%0d fs1@%0d", first_fs0, first_fs1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
